// File: rtl/ltl_mon_pkg.sv
// Shared definitions for the cluster LTL violation collectors.
// Every cluster collector uses the same property count, event id width
// and timestamp width. Keeping them here keeps the event records of all
// collectors identical.
package ltl_mon_pkg;

    localparam int NUM_PROPS = 10;
    localparam int ID_WIDTH  = 4;
    localparam int TS_WIDTH  = 16;

    // One queued detection: which property fired and when it was seen
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [TS_WIDTH-1:0] ts;
    } ltl_evt_t;

endpackage

// File: rtl/ltl_violation_collector_c5_if.sv
// Event stream between the collector and the core-side reporting logic.
// The collector is the master and presents the FIFO head. The consumer
// is the slave and accepts the head with evt_ready.
interface ltl_violation_collector_c5_if;
    import ltl_mon_pkg::*;

    logic                evt_valid;
    logic                evt_ready;
    logic [ID_WIDTH-1:0] evt_id;
    logic [TS_WIDTH-1:0] evt_ts;

    modport master (output evt_valid, output evt_id, output evt_ts, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_ts, output evt_ready);

endinterface

// File: rtl/ltl_evt_fifo.sv
// Small show-ahead event FIFO.
// Each pointer has one extra wrap bit, which separates full from empty.
// A push and a pop may happen in the same cycle at any occupancy. When
// the FIFO is full, a push is taken only if a pop frees the head slot in
// that cycle.
module ltl_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Move the read and write pointers. Reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Write the pushed entry. The storage needs no reset because the
    // pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ltl_violation_collector_c5.sv
// Cluster-5 load/store-word LTL violation collector.
// This block edge-detects the property match lines and timestamps each
// new detection. A pending bit holds each detection until a lowest-index
// arbiter moves it into the event FIFO. It also keeps sticky flags, an
// interrupt level and a saturating count of lost detections. A detection
// is lost only when a property rises again while its pending bit is set.
module ltl_violation_collector_c5
    import ltl_mon_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_PROPS-1:0]     hits,
    input  logic [NUM_PROPS-1:0]     mask,
    input  logic [NUM_PROPS-1:0]     sticky_clr,
    output logic [NUM_PROPS-1:0]     sticky,
    output logic [OVF_WIDTH-1:0]     overflow_cnt,
    output logic                     irq,
    ltl_violation_collector_c5_if.master evt
);
    localparam int CNT_W = $clog2(NUM_PROPS + 1);

    logic [TS_WIDTH-1:0]  ts_cnt;
    logic [TS_WIDTH-1:0]  ts_hold [NUM_PROPS];
    logic [NUM_PROPS-1:0] hits_q;
    logic [NUM_PROPS-1:0] pending;
    logic [NUM_PROPS-1:0] rise;
    logic [NUM_PROPS-1:0] grant;
    logic [NUM_PROPS-1:0] coalesce;
    logic [ID_WIDTH-1:0]  grant_id;
    logic                 pend_any;
    logic                 push;
    logic                 pop;
    logic                 can_accept;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_W-1:0]     coal_num;
    logic [OVF_WIDTH:0]   ovf_sum;
    ltl_evt_t             push_evt;
    ltl_evt_t             head_evt;

    assign rise       = hits & ~hits_q & mask & {NUM_PROPS{run}};
    assign pop        = !fifo_empty && evt.evt_ready;
    assign can_accept = !fifo_full || pop;
    assign push       = pend_any && can_accept;
    assign coalesce   = rise & pending & ~grant;

    assign push_evt.id = grant_id;
    assign push_evt.ts = ts_hold[grant_id];

    // Pick the lowest-index pending property. It is granted only when the
    // FIFO can take it this cycle.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        pend_any = 1'b0;
        for (int i = NUM_PROPS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_id = ID_WIDTH'(i);
                pend_any = 1'b1;
            end
        end
        if (push) grant[grant_id] = 1'b1;
    end

    // Count this cycle's coalesced rises and form the unsaturated sum.
    always_comb begin
        coal_num = '0;
        for (int i = 0; i < NUM_PROPS; i++) begin
            coal_num = coal_num + CNT_W'(coalesce[i]);
        end
        ovf_sum = {1'b0, overflow_cnt} + (OVF_WIDTH+1)'(coal_num);
    end

    // Timestamp counter and input history. Both freeze while run is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            hits_q <= '0;
        end else if (run) begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            hits_q <= hits;
        end
    end

    // Pending detections and their capture timestamps. A bit granted in
    // the same cycle it rises is re-armed with the new timestamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_PROPS; i++) ts_hold[i] <= '0;
        end else begin
            pending <= (pending & ~grant) | rise;
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (rise[i] && (!pending[i] || grant[i])) ts_hold[i] <= ts_cnt;
            end
        end
    end

    // Sticky flags (a set beats a clear), the registered interrupt, and
    // the saturating lost-detection counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky       <= '0;
            irq          <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | rise;
            irq    <= |sticky;
            if (ovf_sum[OVF_WIDTH]) overflow_cnt <= '1;
            else                    overflow_cnt <= ovf_sum[OVF_WIDTH-1:0];
        end
    end

    ltl_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ltl_evt_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_evt),
        .dout  (head_evt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_id    = fifo_empty ? '0 : head_evt.id;
    assign evt.evt_ts    = fifo_empty ? '0 : head_evt.ts;

endmodule

// File: tb/tb_ltl_violation_collector_c5.sv
// Self-checking bench for the cluster-5 LTL violation collector.
// A queue-based reference model follows the DUT on every cycle. Directed
// tables and sequences also check the hand-derived corner cases.
module tb_ltl_violation_collector_c5;

    localparam int NP    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [NP-1:0] hits;
    logic [NP-1:0] mask;
    logic [NP-1:0] sticky_clr;
    logic [NP-1:0] sticky;
    logic [7:0]    overflow_cnt;
    logic          irq;

    int vectors     = 0;
    int miscompares = 0;

    ltl_violation_collector_c5_if ev();

    ltl_violation_collector_c5 dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .hits         (hits),
        .mask         (mask),
        .sticky_clr   (sticky_clr),
        .sticky       (sticky),
        .overflow_cnt (overflow_cnt),
        .irq          (irq),
        .evt          (ev)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then wait until the next falling edge
    task automatic applyStimulus(input logic r, input logic rn, input logic [NP-1:0] h,
                                 input logic [NP-1:0] m, input logic [NP-1:0] c, input logic rdy);
        reset        = r;
        run          = rn;
        hits         = h;
        mask         = m;
        sticky_clr   = c;
        ev.evt_ready = rdy;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model built on a queue of pending-event records
    // ------------------------------------------------------------------
    typedef struct { int id; int ts; } mevt_t;
    mevt_t         m_q[$];
    logic [15:0]   m_ts     = '0;
    logic [15:0]   m_hold [NP];
    logic [NP-1:0] m_hq     = '0;
    logic [NP-1:0] m_pend   = '0;
    logic [NP-1:0] m_sticky = '0;
    logic          m_irq    = 1'b0;
    int            m_ovf    = 0;
    logic [NP-1:0] m_rise;
    int            m_g;
    mevt_t         m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_ts = '0; m_hq = '0; m_pend = '0; m_sticky = '0; m_irq = 1'b0; m_ovf = 0;
            for (int i = 0; i < NP; i++) m_hold[i] = '0;
        end else begin
            m_rise   = hits & ~m_hq & mask & {NP{run}};
            m_irq    = (m_sticky != '0);
            m_sticky = (m_sticky & ~sticky_clr) | m_rise;
            if (m_q.size() > 0 && ev.evt_ready) m_q.delete(0);
            m_g = -1;
            if (m_q.size() < DEPTH)
                for (int i = NP - 1; i >= 0; i--) if (m_pend[i]) m_g = i;
            if (m_g >= 0) begin
                m_e.id = m_g;
                m_e.ts = int'(m_hold[m_g]);
                m_q.push_back(m_e);
                m_pend[m_g] = 1'b0;
            end
            for (int i = 0; i < NP; i++) begin
                if (m_rise[i]) begin
                    if (m_pend[i]) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
                    else begin
                        m_pend[i] = 1'b1;
                        m_hold[i] = m_ts;
                    end
                end
            end
            if (run) begin
                m_hq = hits;
                m_ts = m_ts + 16'd1;
            end
        end
    end

    // Compare all DUT outputs with the model on every falling edge
    always @(negedge clk) begin
        checkOutput("mdl_valid",  {31'd0, ev.evt_valid}, {31'd0, m_q.size() > 0});
        checkOutput("mdl_id",     {28'd0, ev.evt_id},    (m_q.size() > 0) ? m_q[0].id : 0);
        checkOutput("mdl_ts",     {16'd0, ev.evt_ts},    (m_q.size() > 0) ? m_q[0].ts : 0);
        checkOutput("mdl_sticky", {22'd0, sticky},       {22'd0, m_sticky});
        checkOutput("mdl_irq",    {31'd0, irq},          {31'd0, m_irq});
        checkOutput("mdl_ovf",    {24'd0, overflow_cnt}, m_ovf);
    end

    // ------------------------------------------------------------------
    // Directed table: single detection, handshake, sticky clear, masking
    // ------------------------------------------------------------------
    typedef struct {
        logic          rst, rn;
        logic [NP-1:0] h, m, c;
        logic          rdy;
        logic          e_valid;
        logic [3:0]    e_id;
        logic [15:0]   e_ts;
        logic [NP-1:0] e_st;
        logic          e_irq;
        logic [7:0]    e_ovf;
    } vec_t;

    vec_t tbl [13];

    int         got[$];
    int         cyc;
    logic [9:0] rh;
    logic [9:0] rm;
    logic [9:0] rc;

    initial begin
        //               rst run  hits    mask     clr    rdy | val id ts     sticky  irq ovf
        tbl[0]  = '{1'b1,1'b0,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[1]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[2]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[3]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[4]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[5]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[6]  = '{1'b0,1'b1,10'h008,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h008,1'b0,8'd0};
        tbl[7]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b1,4'd3,16'd5,10'h008,1'b1,8'd0};
        tbl[8]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b1, 1'b0,4'd0,16'd0,10'h008,1'b1,8'd0};
        tbl[9]  = '{1'b0,1'b1,10'h000,10'h3FF,10'h008,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b1,8'd0};
        tbl[10] = '{1'b0,1'b1,10'h000,10'h3FF,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[11] = '{1'b0,1'b1,10'h004,10'h3FB,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};
        tbl[12] = '{1'b0,1'b1,10'h000,10'h3FB,10'h000,1'b0, 1'b0,4'd0,16'd0,10'h000,1'b0,8'd0};

        reset = 1'b1; run = 1'b0; hits = '0; mask = '1; sticky_clr = '0; ev.evt_ready = 1'b0;
        @(negedge clk);

        $display("[TB] directed table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].rn, tbl[i].h, tbl[i].m, tbl[i].c, tbl[i].rdy);
            checkOutput($sformatf("tbl%0d_valid", i),  {31'd0, ev.evt_valid}, {31'd0, tbl[i].e_valid});
            checkOutput($sformatf("tbl%0d_id", i),     {28'd0, ev.evt_id},    {28'd0, tbl[i].e_id});
            checkOutput($sformatf("tbl%0d_ts", i),     {16'd0, ev.evt_ts},    {16'd0, tbl[i].e_ts});
            checkOutput($sformatf("tbl%0d_sticky", i), {22'd0, sticky},       {22'd0, tbl[i].e_st});
            checkOutput($sformatf("tbl%0d_irq", i),    {31'd0, irq},          {31'd0, tbl[i].e_irq});
            checkOutput($sformatf("tbl%0d_ovf", i),    {24'd0, overflow_cnt}, {24'd0, tbl[i].e_ovf});
        end

        // Three rises in one cycle at ts=20 leave in index order
        $display("[TB] simultaneous rise");
        applyStimulus(1, 0, 0, '1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, '1, 0, 1);
        applyStimulus(0, 1, 10'h211, '1, 0, 1);
        checkOutput("sim_sticky", {22'd0, sticky}, 32'h211);
        checkOutput("sim_pre_valid", {31'd0, ev.evt_valid}, 0);
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("sim_e0", {ev.evt_valid, 11'd0, ev.evt_id, ev.evt_ts}, {1'b1, 11'd0, 4'd0, 16'd20});
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("sim_e1", {ev.evt_valid, 11'd0, ev.evt_id, ev.evt_ts}, {1'b1, 11'd0, 4'd4, 16'd20});
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("sim_e2", {ev.evt_valid, 11'd0, ev.evt_id, ev.evt_ts}, {1'b1, 11'd0, 4'd9, 16'd20});
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("sim_empty", {31'd0, ev.evt_valid}, 0);

        // Backpressure: ten properties with a stalled consumer
        $display("[TB] backpressure");
        applyStimulus(1, 0, 0, '1, 0, 0);
        applyStimulus(0, 1, 10'h3FF, '1, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 10'h3FF, '1, 0, 0);
        checkOutput("bp_head", {ev.evt_valid, 27'd0, ev.evt_id}, {1'b1, 27'd0, 4'd0});
        applyStimulus(0, 1, 10'h000, '1, 0, 0);
        applyStimulus(0, 1, 10'h100, '1, 0, 0);
        checkOutput("bp_ovf", {24'd0, overflow_cnt}, 1);
        applyStimulus(0, 1, 10'h000, '1, 0, 0);
        got.delete();
        cyc = 0;
        while (cyc < 40 && !(got.size() > 0 && !ev.evt_valid)) begin
            if (ev.evt_valid) got.push_back(int'(ev.evt_id));
            applyStimulus(0, 1, 0, '1, 0, 1);
            cyc++;
        end
        checkOutput("bp_drain_timeout", {31'd0, cyc >= 40}, 0);
        checkOutput("bp_count", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            checkOutput($sformatf("bp_order%0d", i), got[i], i);
        checkOutput("bp_ovf_after", {24'd0, overflow_cnt}, 1);

        // Mask and run gating
        $display("[TB] mask/run gating");
        applyStimulus(1, 0, 0, '1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, '1, 0, 0);
        applyStimulus(0, 1, 10'h004, 10'h3FB, 0, 0);
        applyStimulus(0, 1, 10'h000, 10'h3FB, 0, 0);
        checkOutput("mask_sticky", {22'd0, sticky}, 0);
        checkOutput("mask_valid", {31'd0, ev.evt_valid}, 0);
        applyStimulus(0, 0, 10'h000, '1, 0, 0);
        applyStimulus(0, 0, 10'h020, '1, 0, 0);
        applyStimulus(0, 0, 10'h020, '1, 0, 0);
        applyStimulus(0, 0, 10'h000, '1, 0, 0);
        checkOutput("run_sticky", {22'd0, sticky}, 0);
        applyStimulus(0, 1, 10'h040, '1, 0, 0);
        applyStimulus(0, 1, 10'h000, '1, 0, 0);
        checkOutput("run_frozen_ts", {ev.evt_valid, 11'd0, ev.evt_id, ev.evt_ts}, {1'b1, 11'd0, 4'd6, 16'd5});

        // Sticky clear racing a rise, then a clear alone
        $display("[TB] sticky clear race");
        applyStimulus(1, 0, 0, '1, 0, 0);
        applyStimulus(0, 1, 0, '1, 0, 1);
        applyStimulus(0, 1, 10'h002, '1, 10'h002, 1);
        checkOutput("race_sticky", {22'd0, sticky}, 32'h002);
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("race_irq", {31'd0, irq}, 1);
        applyStimulus(0, 1, 0, '1, 10'h002, 1);
        checkOutput("clr_sticky", {22'd0, sticky}, 0);
        checkOutput("clr_irq_lag", {31'd0, irq}, 1);
        applyStimulus(0, 1, 0, '1, 0, 1);
        checkOutput("clr_irq_fall", {31'd0, irq}, 0);

        // Reset with three queued events and hits[0] held high
        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 0, '1, 0, 0);
        applyStimulus(0, 1, 0, '1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 10'h00E, '1, 0, 0);
        checkOutput("rst_pre_valid", {31'd0, ev.evt_valid}, 1);
        applyStimulus(1, 1, 10'h001, '1, 0, 0);
        checkOutput("rst_outputs", {ev.evt_valid, irq, ev.evt_id, ev.evt_ts, overflow_cnt},
                    {1'b0, 1'b0, 4'd0, 16'd0, 8'd0});
        checkOutput("rst_sticky", {22'd0, sticky}, 0);
        got.delete();
        cyc = 0;
        while (cyc < 12) begin
            applyStimulus(0, 1, 10'h001, '1, 0, 1);
            if (ev.evt_valid) begin
                got.push_back(int'(ev.evt_id));
                checkOutput("rst_evt_ts", {16'd0, ev.evt_ts}, 0);
            end
            cyc++;
        end
        checkOutput("rst_evt_count", got.size(), 1);
        if (got.size() > 0) checkOutput("rst_evt_id", got[0], 0);

        // Overflow counter saturation with a stalled consumer
        $display("[TB] overflow saturation");
        applyStimulus(1, 0, 0, '1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1, 10'h3FF, '1, 0, 0);
            applyStimulus(0, 1, 10'h000, '1, 0, 0);
        end
        checkOutput("ovf_saturate", {24'd0, overflow_cnt}, 255);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        applyStimulus(1, 0, 0, '1, 0, 0);
        rh = '0;
        for (int i = 0; i < 3000; i++) begin
            rm = '1;
            rc = '0;
            for (int b = 0; b < NP; b++) begin
                if ($urandom_range(0, 7) == 0)  rh[b] = ~rh[b];
                if ($urandom_range(0, 15) == 0) rm[b] = 1'b0;
                if ($urandom_range(0, 31) == 0) rc[b] = 1'b1;
            end
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 9) != 0,
                          rh, rm, rc,
                          ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
